fetch_unit: RTL and testbench

Instruction fetch stage of the VanilaCore RV32I pipeline, sitting directly upstream of `decoder`. Holds the program counter, issues word reads on a simple req/ack instruction bus, and presents each fetched word with its PC to the decoder through a valid/ready handshake. Handles redirects from execute, including redirects that arrive while a bus read is outstanding, and latches a fault on misaligned targets.

---
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_unit.sv | 199 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//
// Bundles every non-clock/reset signal of the VanilaCore fetch stage: the
// req/ack instruction bus, the redirect port from execute, and the
// valid/ready instruction port towards the decoder.
//
//   master modport : the fetch unit side.
//   slave  modport : the environment side (memory, execute, decoder).
//
// Signals:
//   mem_req    fetch -> mem   read request, held until mem_ack
//   mem_addr   fetch -> mem   word-aligned byte address
//   mem_ack    mem -> fetch   read complete, mem_rdata valid
//   mem_rdata  mem -> fetch   instruction word
//   jump       exe -> fetch   one-cycle redirect pulse
//   jump_addr  exe -> fetch   redirect target
//   IR         fetch -> dec   instruction word (NOP when not valid)
//   ir_pc      fetch -> dec   PC of IR
//   ir_valid   fetch -> dec   IR/ir_pc hold a live instruction
//   ir_ready   dec -> fetch   decoder accepts
//   fault      fetch -> exe   sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] IR;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        fault;

  modport master (
    output mem_req, mem_addr, IR, ir_pc, ir_valid, fault,
    input  mem_ack, mem_rdata, jump, jump_addr, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, IR, ir_pc, ir_valid, fault,
    output mem_ack, mem_rdata, jump, jump_addr, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the VanilaCore RV32I pipeline. Holds the program
// counter, issues one word read at a time on a req/ack bus, and presents each
// fetched word with its PC to the decoder through a valid/ready handshake.
// Redirects from execute are honoured immediately when no bus read is in
// flight, or deferred until the outstanding read completes (its data is then
// discarded). A misaligned redirect target halts the unit with a sticky fault
// that only reset clears.
//
// Parameters:
//   RESET_PC  byte address of the first fetch after reset (word aligned)
//   NOP       value driven on IR while no instruction is valid
//
// Ports:
//   clk   single clock, posedge
//   rst   synchronous, active-high reset
//   bus   fetch_unit_if.master (memory bus, redirect, decoder handshake)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  // FETCH: request outstanding (or about to be issued)
  // HOLD : instruction presented to the decoder
  // FAULT: halted after a misaligned redirect
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        fault_q, fault_d;
  logic        mem_req_q, mem_req_d;

  logic        jump_bad;
  logic        ack_live;

  // A redirect to a non-word address is fatal regardless of state.
  assign jump_bad = bus.jump && (bus.jump_addr[1:0] != 2'b00);

  // An ack only counts while our request is actually on the bus. This masks
  // any stale response in the cycle after reset, when the state is already
  // FETCH but the registered request has not yet risen.
  assign ack_live = mem_req_q && bus.mem_ack;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      kill_q        <= 1'b0;
      ir_q          <= NOP;
      ir_pc_q       <= 32'h0000_0000;
      ir_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      mem_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      kill_q        <= kill_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      fault_q       <= fault_d;
      mem_req_q     <= mem_req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        // A redirect never leaves FETCH unless it faults: either the target
        // is fetched directly or the in-flight read is killed first.
        if (bus.jump) begin
          state_d = jump_bad ? S_FAULT : S_FETCH;
        end else if (ack_live && !kill_q) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.jump) begin
          state_d = jump_bad ? S_FAULT : S_FETCH;
        end else if (bus.ir_ready) begin
          state_d = S_FETCH;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    kill_d        = kill_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fault_d       = fault_q;

    // The request is registered: it is high in every cycle spent in FETCH
    // except the one right after reset.
    mem_req_d     = (state_d == S_FETCH);

    unique case (state_q)
      S_FETCH: begin
        if (bus.jump) begin
          if (jump_bad) begin
            fault_d    = 1'b1;
            ir_valid_d = 1'b0;
            ir_d       = NOP;
            kill_d     = 1'b0;
          end else if (ack_live || !mem_req_q) begin
            // Nothing left in flight after this edge: retarget right away.
            // This also overrides any earlier pending redirect.
            pc_d   = bus.jump_addr;
            kill_d = 1'b0;
          end else begin
            // Read still pending: mem_addr must stay put until the ack, so
            // park the target and drop the response when it arrives. A later
            // jump simply overwrites the parked target.
            kill_d        = 1'b1;
            redirect_pc_d = bus.jump_addr;
          end
        end else if (ack_live) begin
          if (kill_q) begin
            pc_d   = redirect_pc_q;
            kill_d = 1'b0;
          end else begin
            ir_d       = bus.mem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      S_HOLD: begin
        if (bus.jump) begin
          // Squash wins over a same-cycle handshake.
          ir_valid_d = 1'b0;
          ir_d       = NOP;
          if (jump_bad) begin
            fault_d = 1'b1;
          end else begin
            pc_d = bus.jump_addr;
          end
        end else if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          ir_d       = NOP;
        end
      end
      S_FAULT: begin
        ir_valid_d = 1'b0;
        ir_d       = NOP;
      end
      default: begin
        ir_valid_d = 1'b0;
        ir_d       = NOP;
      end
    endcase
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = pc_q;
  assign bus.IR       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small memory model answers every request
// with addr ^ 32'hA5A5_0000 after a programmable number of wait states. A
// cycle table covers steady-state fetch, decoder back-pressure and aligned
// redirects; hand-written sequences cover wait states, a killed in-flight
// read, a misaligned redirect and reset in the middle of a read.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jaddr = 32'h0;
  logic        force_ack = 1'b0;
  int          waits = 0;
  int          cnt = 0;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack after 'waits' extra cycles of a held request.
  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) cnt <= 0;
    else                             cnt <= cnt + 1;
  end

  assign bus.mem_ack   = (bus.mem_req && (cnt == waits)) || force_ack;
  assign bus.mem_rdata = force_ack ? 32'hDEAD_BEEF : (bus.mem_addr ^ XORK);
  assign bus.jump      = jmp;
  assign bus.jump_addr = jaddr;
  assign bus.ir_ready  = rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jmp = 1'b0;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        jmp;
    logic [31:0] jaddr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_irpc;
    logic [31:0] e_ir;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic j, input logic [31:0] ja,
                     input logic eq, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rdy = r; v.jmp = j; v.jaddr = ja;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev;
    v.e_irpc = ep; v.e_ir = ei; v.e_fault = 1'b0;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_a;
    int          n;
    bit          done;
    bit          found;
    bit          after_kill;
    bit          killed;
    int          nval;
    logic [31:0] exp_pcs [2];

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",    32'(bus.mem_req),  32'h0);
    chk("rst_valid",  32'(bus.ir_valid), 32'h0);
    chk("rst_ir",     bus.IR,            NOP);
    chk("rst_irpc",   bus.ir_pc,         32'h0);
    chk("rst_fault",  32'(bus.fault),    32'h0);
    chk("rst_addr",   bus.mem_addr,      32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- cycle table, zero-wait memory ----------------
    // rdy jmp jaddr | req addr valid ir_pc IR
    add(1, 0, 0,          0, 32'h00, 0, 32'h00, NOP);
    add(1, 0, 0,          1, 32'h00, 0, 32'h00, NOP);
    add(1, 0, 0,          0, 32'h04, 1, 32'h00, XORK ^ 32'h00);
    add(1, 0, 0,          1, 32'h04, 0, 32'h00, NOP);
    add(1, 0, 0,          0, 32'h08, 1, 32'h04, XORK ^ 32'h04);
    add(1, 0, 0,          1, 32'h08, 0, 32'h04, NOP);
    add(1, 0, 0,          0, 32'h0C, 1, 32'h08, XORK ^ 32'h08);
    add(1, 0, 0,          1, 32'h0C, 0, 32'h08, NOP);
    add(1, 0, 0,          0, 32'h10, 1, 32'h0C, XORK ^ 32'h0C);
    add(1, 0, 0,          1, 32'h10, 0, 32'h0C, NOP);
    // decoder stalls 5 cycles on PC 0x10
    add(0, 0, 0,          0, 32'h14, 1, 32'h10, XORK ^ 32'h10);
    add(0, 0, 0,          0, 32'h14, 1, 32'h10, XORK ^ 32'h10);
    add(0, 0, 0,          0, 32'h14, 1, 32'h10, XORK ^ 32'h10);
    add(0, 0, 0,          0, 32'h14, 1, 32'h10, XORK ^ 32'h10);
    add(0, 0, 0,          0, 32'h14, 1, 32'h10, XORK ^ 32'h10);
    add(1, 0, 0,          0, 32'h14, 1, 32'h10, XORK ^ 32'h10);
    add(1, 0, 0,          1, 32'h14, 0, 32'h10, NOP);
    // redirect in HOLD squashes even with ready high
    add(1, 1, 32'h40,     0, 32'h18, 1, 32'h14, XORK ^ 32'h14);
    add(1, 0, 0,          1, 32'h40, 0, 32'h14, NOP);
    add(1, 0, 0,          0, 32'h44, 1, 32'h40, XORK ^ 32'h40);
    // redirect in FETCH coinciding with ack drops the data
    add(1, 1, 32'h80,     1, 32'h44, 0, 32'h40, NOP);
    add(1, 0, 0,          1, 32'h80, 0, 32'h40, NOP);
    // redirect to the last word, then PC wraps to 0
    add(1, 1, 32'hFFFF_FFFC, 0, 32'h84, 1, 32'h80, XORK ^ 32'h80);
    add(1, 0, 0,          1, 32'hFFFF_FFFC, 0, 32'h80, NOP);
    add(1, 0, 0,          0, 32'h00, 1, 32'hFFFF_FFFC, XORK ^ 32'hFFFF_FFFC);
    add(1, 0, 0,          1, 32'h00, 0, 32'hFFFF_FFFC, NOP);
    add(1, 0, 0,          0, 32'h04, 1, 32'h00, XORK ^ 32'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      rdy   = tbl[i].rdy;
      jmp   = tbl[i].jmp;
      jaddr = tbl[i].jaddr;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i),   32'(bus.mem_req),  32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_addr", i),  bus.mem_addr,      tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.ir_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_irpc", i),  bus.ir_pc,         tbl[i].e_irpc);
      chk($sformatf("tbl%0d_ir", i),    bus.IR,            tbl[i].e_ir);
      chk($sformatf("tbl%0d_fault", i), 32'(bus.fault),    32'(tbl[i].e_fault));
      @(posedge clk); #1;
    end
    jmp = 1'b0;

    // ---------------- 3 wait states: fetches 0x0 and 0x4 ----------------
    waits = 3;
    rdy   = 1'b1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      exp_a = 32'(k * 4);
      n = 0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (bus.mem_req) begin
          chk("ws_addr_stable", bus.mem_addr, exp_a);
          n++;
          if (bus.mem_ack) done = 1;
        end
      end
      chk("ws_req_cycles", 32'(n), 32'd4);
      @(negedge clk);
      chk("ws_valid", 32'(bus.ir_valid), 32'h1);
      chk("ws_irpc",  bus.ir_pc,         exp_a);
      chk("ws_ir",    bus.IR,            exp_a ^ XORK);
    end

    // ---------------- redirect during the 2nd wait cycle of fetch 0x8 ----------------
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 32'h8) found = 1;
    end
    chk("jk_found_fetch8", 32'(found), 32'h1);
    @(posedge clk); #1;
    jmp = 1'b1; jaddr = 32'h100;
    @(posedge clk); #1;
    jmp = 1'b0;
    exp_pcs[0] = 32'h100;
    exp_pcs[1] = 32'h104;
    nval = 0;
    after_kill = 0;
    killed = 0;
    for (int c = 0; c < 40 && nval < 2; c++) begin
      @(negedge clk);
      if (after_kill) begin
        chk("jk_req_after_kill",  32'(bus.mem_req), 32'h1);
        chk("jk_addr_after_kill", bus.mem_addr,     32'h100);
        after_kill = 0;
      end
      if (bus.mem_req && !killed) begin
        chk("jk_addr_held", bus.mem_addr, 32'h8);
        if (bus.mem_ack) begin
          killed = 1;
          after_kill = 1;
        end
      end
      if (bus.ir_valid) begin
        chk("jk_irpc", bus.ir_pc, exp_pcs[nval]);
        chk("jk_ir",   bus.IR,    exp_pcs[nval] ^ XORK);
        nval++;
      end
    end
    chk("jk_valid_count", 32'(nval), 32'd2);

    // ---------------- misaligned redirect while in HOLD ----------------
    waits = 0;
    rdy   = 1'b0;
    do_reset();
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.ir_valid) found = 1;
    end
    chk("ft_hold_reached", 32'(found), 32'h1);
    @(posedge clk); #1;
    jmp = 1'b1; jaddr = 32'h102;
    @(posedge clk); #1;
    jmp = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk("ft_fault", 32'(bus.fault),    32'h1);
    chk("ft_valid", 32'(bus.ir_valid), 32'h0);
    chk("ft_req",   32'(bus.mem_req),  32'h0);
    chk("ft_ir",    bus.IR,            NOP);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      jmp = (c == 2); jaddr = 32'h200;
      @(negedge clk);
      chk("ft_stuck_fault", 32'(bus.fault),    32'h1);
      chk("ft_stuck_req",   32'(bus.mem_req),  32'h0);
      chk("ft_stuck_valid", 32'(bus.ir_valid), 32'h0);
    end
    @(posedge clk); #1;
    jmp = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ft_rst_fault", 32'(bus.fault),   32'h0);
    chk("ft_rst_req",   32'(bus.mem_req), 32'h0);
    @(negedge clk);
    chk("ft_resume_req",  32'(bus.mem_req), 32'h1);
    chk("ft_resume_addr", bus.mem_addr,     32'h0);

    // ---------------- reset in the middle of a read of 0x20 ----------------
    waits = 3;
    rdy   = 1'b1;
    do_reset();
    found = 0;
    for (int c = 0; c < 150 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 32'h20) found = 1;
    end
    chk("rm_found_fetch20", 32'(found), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; force_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rm_req",   32'(bus.mem_req),  32'h0);
    chk("rm_valid", 32'(bus.ir_valid), 32'h0);
    chk("rm_ir",    bus.IR,            NOP);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("rm_valid_stale", 32'(bus.ir_valid), 32'h0);
    chk("rm_req_again",   32'(bus.mem_req),  32'h1);
    chk("rm_addr_again",  bus.mem_addr,      32'h0);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.ir_valid) found = 1;
    end
    chk("rm_first_valid", 32'(found), 32'h1);
    chk("rm_first_irpc",  bus.ir_pc,  32'h0);
    chk("rm_first_ir",    bus.IR,     XORK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
